uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Round-robin scheduler sharing the single UART transmitter (8N1, 115200 bps @ 50 MHz)
//  between NUM_REQ byte producers, e.g. the CPU store path and the telemetry/debug path.
//  Accepts one byte per valid/ready handshake and drives the tx core's begin/data inputs.
//  It then tracks tx_busy_flag until the frame completes.
//  Sits between the requesters and the tx core, which it alone drives.
// PARAMETERS
//  NUM_REQ       2   number of requesters, >=2; GW = $clog2(NUM_REQ)
//  BUSY_TIMEOUT  16  cycles to wait for tx_busy_flag to rise after a start pulse, >=2
// PORTS
//  clk            in   1          system clock, rising edge, 50 MHz
//  rst            in   1          synchronous reset, active-high
//  req_valid      in   NUM_REQ    per-requester byte available
//  req_data       in   8*NUM_REQ  byte of requester i at [8*i+7:8*i]
//  req_ready      out  NUM_REQ    one-hot, 1-cycle accept pulse
//  tx_begin_flag  out  1          1-cycle start pulse to tx core
//  tx_data        out  8          byte to tx core, stable from START until back in IDLE
//  tx_busy_flag   in   1          tx core busy, frame in progress
//  grant_id       out  GW         index of last granted requester
//  sched_busy     out  1          high in any state other than IDLE
//  err_timeout    out  1          1-cycle pulse when tx core never went busy
// BEHAVIOUR
//  Reset: req_ready=0, tx_begin_flag=0, tx_data=8'h00, grant_id=NUM_REQ-1
//   (first grant goes to index 0), sched_busy=0, err_timeout=0, state=IDLE, timeout cnt=0.
//  Reset mid-operation: the in-flight byte is dropped; outputs take reset values at that edge.
//  All outputs are registered.
//  FSM states: IDLE -> START -> WAIT_BUSY -> WAIT_DONE -> IDLE.
//  IDLE:
//   - Grants only when tx_busy_flag==0 and any req_valid is high.
//   - Winner = first valid index scanning grant_id+1, grant_id+2, ... modulo NUM_REQ
//     (wrap at NUM_REQ-1 -> 0).
//   - Same edge: req_ready[winner]=1, tx_data<=req_data[winner], grant_id<=winner; go START.
//   - tx_busy_flag high in IDLE (foreign/late frame): no grant; stay.
//  START:
//   - tx_begin_flag=1 for exactly this cycle; cnt<=0; go WAIT_BUSY.
//   - Latency: req accept to begin pulse = 1 cycle.
//  WAIT_BUSY:
//   - tx_busy_flag==1: go WAIT_DONE.
//   - Else cnt++. At cnt==BUSY_TIMEOUT-1 with busy still low: err_timeout=1 one cycle;
//     go IDLE; byte dropped, no retry.
//  WAIT_DONE:
//   - Stays until tx_busy_flag==0, then IDLE.
//   - Next grant earliest the cycle after IDLE is entered
//     (min 1 idle cycle between consecutive begin pulses).
//  Handshake rules:
//   - req_ready asserted only in IDLE, never two bits at once.
//   - A requester holds valid/data until it sees ready. Dropping valid before ready is legal;
//     the byte is simply not sent.
//   - req_data is sampled only on the accept edge.
//  Fairness: a requester asserting valid continuously is granted within NUM_REQ grants.
//  sched_busy = (state != IDLE).
// TESTING
//  1. Single req0 byte 8'hA5, tx model busy 3 cycles after begin, for 100 cycles
//     -> ready0 1 pulse, begin 1 cycle later, tx_data=A5, back to IDLE after busy falls.
//  2. req0=8'h11 and req1=8'h22 both held valid from reset
//     -> begin order 11,22,11,22...; grant_id alternates 0,1,0,1.
//  3. tx model never asserts busy -> err_timeout pulse exactly BUSY_TIMEOUT cycles after
//     begin; FSM in IDLE; next valid granted.
//  4. tx_busy_flag held high externally while req0 valid -> no ready, no begin until busy low.
//  5. rst pulsed during WAIT_DONE -> next edge all outputs at reset values;
//     first grant after reset goes to requester 0.
//  6. NUM_REQ=3, only req2 valid, grant_id=2
//     -> wrap scan 0,1,2 grants req2 again; no lockout.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Round-robin arbiter that shares one 8N1 UART transmitter core between
//   NUM_REQ byte producers. It accepts one byte per valid/ready handshake and
//   pulses the core's begin input. It then follows tx_busy_flag until the
//   frame is finished.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous reset, active-high
//   req_valid      per-requester byte available
//   req_data       byte of requester i at [8*i+7:8*i]
//   req_ready      one-hot accept pulse (one cycle)
//   tx_begin_flag  one-cycle start pulse to the tx core
//   tx_data        byte to the tx core, held until the next grant
//   tx_busy_flag   tx core busy (frame in progress)
//   grant_id       index of the last granted requester
//   sched_busy     high whenever the FSM is not idle
//   err_timeout    one-cycle pulse when the core never went busy
//
// state       | meaning
// ------------+------------------------------------------------------
// S_IDLE      | waiting for a valid request while the tx core is quiet
// S_START     | byte latched, begin pulse goes out on this edge
// S_WAIT_BUSY | waiting up to BUSY_TIMEOUT cycles for the core to go busy
// S_WAIT_DONE | frame in flight, waiting for busy to drop
module uart_tx_scheduler #(
  parameter int NUM_REQ      = 2,
  parameter int BUSY_TIMEOUT = 16,
  localparam int GW          = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_begin_flag,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy_flag,
  output logic [GW-1:0]        grant_id,
  output logic                 sched_busy,
  output logic                 err_timeout
);

  localparam int CW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_START     = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [GW-1:0] win;
  logic [GW:0]   scan;
  logic [7:0]    win_data;

  // Scan from farthest to nearest so the last hit is the first valid index
  // after grant_id; the extra bit keeps grant_id+k from overflowing before
  // the modulo fold.
  always_comb begin
    win  = grant_id;
    scan = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      scan = {1'b0, grant_id} + (GW+1)'(k);
      if (scan >= (GW+1)'(NUM_REQ)) scan = scan - (GW+1)'(NUM_REQ);
      if (req_valid[scan[GW-1:0]]) win = scan[GW-1:0];
    end
  end

  always_comb begin
    win_data = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == GW'(i)) win_data = req_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      req_ready     <= '0;
      tx_begin_flag <= 1'b0;
      tx_data       <= 8'h00;
      grant_id      <= GW'(NUM_REQ-1);
      sched_busy    <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      req_ready     <= '0;
      tx_begin_flag <= 1'b0;
      err_timeout   <= 1'b0;
      case (state)
        S_IDLE: begin
          // A busy core here is a foreign or late frame: never start on top of it.
          if (!tx_busy_flag && (|req_valid)) begin
            req_ready  <= NUM_REQ'(1) << win;
            tx_data    <= win_data;
            grant_id   <= win;
            state      <= S_START;
            sched_busy <= 1'b1;
          end
        end
        S_START: begin
          tx_begin_flag <= 1'b1;
          cnt           <= '0;
          state         <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (tx_busy_flag) begin
            state <= S_WAIT_DONE;
          end else if (cnt == CW'(BUSY_TIMEOUT-1)) begin
            // Byte is dropped; the requester already saw its ready.
            err_timeout <= 1'b1;
            state       <= S_IDLE;
            sched_busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy_flag) begin
            state      <= S_IDLE;
            sched_busy <= 1'b0;
          end
        end
        default: begin
          state      <= S_IDLE;
          sched_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler (three requesters so the wrap-around scan
// is exercised). A timestamp-based transaction model predicts every output
// each cycle; directed scenarios add targeted checks on top.
module tb_uart_tx_scheduler;

  localparam int NR = 3;
  localparam int BT = 16;
  localparam int GW = $clog2(NR);

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [8*NR-1:0]   req_data;
  logic [NR-1:0]     req_ready;
  logic              tx_begin_flag;
  logic [7:0]        tx_data;
  logic              tx_busy_flag;
  logic [GW-1:0]     grant_id;
  logic              sched_busy;
  logic              err_timeout;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.NUM_REQ(NR), .BUSY_TIMEOUT(BT)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .tx_begin_flag (tx_begin_flag),
    .tx_data       (tx_data),
    .tx_busy_flag  (tx_busy_flag),
    .grant_id      (grant_id),
    .sched_busy    (sched_busy),
    .err_timeout   (err_timeout)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: a frame is "active" from its accept until it finishes
  bit         m_active;
  bit         m_seen_busy;
  int         m_last;
  int         m_accept;
  logic [7:0] m_data;
  int         cyc;

  // logs from observed DUT outputs
  logic [7:0] begin_log[$];
  int         grant_log[$];
  int         ready_cyc, begin_cyc, err_cyc;

  // tx core model
  int tx_mode;          // 0 normal, 1 never busy, 2 forced busy
  int tx_fixed_dly, tx_fixed_len;
  bit tx_pend;
  int tx_dly, tx_len;
  bit rand_mode;

  function automatic int rr_pick(input int last, input logic [NR-1:0] v);
    int r = -1;
    for (int k = NR; k >= 1; k--)
      if (v[(last + k) % NR]) r = (last + k) % NR;
    return r;
  endfunction

  task automatic step();
    logic [NR-1:0]   v;
    logic [8*NR-1:0] d;
    logic            b, r;
    logic [NR-1:0]   e_ready;
    logic            e_begin, e_err;
    int              w, s;
    v = req_valid; d = req_data; b = tx_busy_flag; r = rst;
    @(posedge clk);
    #1;
    cyc++;
    e_ready = '0; e_begin = 1'b0; e_err = 1'b0;
    if (r) begin
      m_active = 0; m_seen_busy = 0; m_last = NR-1; m_data = 8'h00;
    end else if (!m_active) begin
      if (!b && (|v)) begin
        w = rr_pick(m_last, v);
        e_ready[w] = 1'b1;
        m_data = d[8*w +: 8];
        m_last = w;
        m_active = 1; m_seen_busy = 0; m_accept = cyc;
      end
    end else begin
      s = cyc - m_accept;
      if (s == 1) e_begin = 1'b1;
      else if (m_seen_busy) begin
        if (!b) m_active = 0;
      end else if (b) m_seen_busy = 1;
      else if (s - 1 == BT) begin
        e_err = 1'b1; m_active = 0;
      end
    end
    check_val("req_ready",   32'(req_ready),     32'(e_ready));
    check_val("tx_begin",    32'(tx_begin_flag), 32'(e_begin));
    check_val("err_timeout", 32'(err_timeout),   32'(e_err));
    check_val("sched_busy",  32'(sched_busy),    32'(m_active));
    check_val("tx_data",     32'(tx_data),       32'(m_data));
    check_val("grant_id",    32'(grant_id),      32'(m_last));
    if (|req_ready) begin grant_log.push_back(int'(grant_id)); ready_cyc = cyc; end
    if (tx_begin_flag) begin begin_log.push_back(tx_data); begin_cyc = cyc; end
    if (err_timeout) err_cyc = cyc;
  endtask

  task automatic tx_model();
    if (tx_mode == 1) tx_busy_flag = 1'b0;
    else if (tx_mode == 2) tx_busy_flag = 1'b1;
    else begin
      if (tx_begin_flag) begin
        tx_pend = 1;
        if (tx_fixed_dly >= 0) tx_dly = tx_fixed_dly;
        else if ($urandom_range(0, 9) == 0) tx_dly = int'($urandom_range(0, BT+2));
        else tx_dly = int'($urandom_range(0, 3));
      end
      if (tx_pend) begin
        if (tx_dly == 0) begin
          tx_busy_flag = 1'b1; tx_pend = 0;
          tx_len = (tx_fixed_len >= 0) ? tx_fixed_len : int'($urandom_range(1, 6));
        end else tx_dly--;
      end else if (tx_busy_flag) begin
        if (tx_len == 0) tx_busy_flag = 1'b0;
        else tx_len--;
      end
    end
  endtask

  task automatic rand_req();
    for (int i = 0; i < NR; i++) begin
      if (req_valid[i] && req_ready[i]) req_valid[i] = 1'b0;
      else if (req_valid[i] && $urandom_range(0, 30) == 0) req_valid[i] = 1'b0;
      else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
        req_valid[i] = 1'b1;
        req_data[8*i +: 8] = 8'($urandom);
      end
    end
  endtask

  task automatic cycle();
    step();
    tx_model();
    if (rand_mode) rand_req();
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; tx_busy_flag = 1'b0; tx_pend = 0; tx_mode = 0;
    cycle(); cycle();
    rst = 1'b0;
    begin_log.delete(); grant_log.delete();
  endtask

  initial begin
    int n;
    rst = 1'b1; req_valid = '0; req_data = '0; tx_busy_flag = 1'b0;
    cyc = 0; m_active = 0; m_seen_busy = 0; m_last = NR-1; m_data = 8'h00; m_accept = 0;
    tx_mode = 0; tx_fixed_dly = 2; tx_fixed_len = 3; tx_pend = 0; tx_dly = 0; tx_len = 0;
    rand_mode = 0; ready_cyc = 0; begin_cyc = 0; err_cyc = 0;
    do_reset();

    // single byte from requester 0
    req_valid[0] = 1'b1; req_data[7:0] = 8'hA5;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (req_ready[0]) req_valid[0] = 1'b0;
    end
    check_val("t1_begin_cnt", 32'(begin_log.size()), 32'd1);
    if (begin_log.size() > 0) check_val("t1_data", 32'(begin_log[0]), 32'hA5);
    check_val("t1_latency", 32'(begin_cyc - ready_cyc), 32'd1);
    check_val("t1_idle", 32'(sched_busy), 32'd0);

    // two requesters held valid from reset alternate
    do_reset();
    req_data[7:0] = 8'h11; req_data[15:8] = 8'h22; req_valid = 3'b011;
    n = 0;
    while (begin_log.size() < 4 && n < 200) begin cycle(); n++; end
    req_valid = '0;
    check_val("t2_begin_cnt", 32'(begin_log.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i < begin_log.size()) check_val("t2_order", 32'(begin_log[i]), (i % 2 == 0) ? 32'h11 : 32'h22);
      if (i < grant_log.size()) check_val("t2_grant", 32'(grant_log[i]), 32'(i % 2));
    end
    for (int i = 0; i < 30; i++) cycle();

    // tx core never goes busy -> timeout, then next request served
    tx_mode = 1; err_cyc = -1;
    req_valid[0] = 1'b1; req_data[7:0] = 8'h33;
    n = 0;
    while (err_cyc < 0 && n < 80) begin
      cycle(); n++;
      if (req_ready[0]) req_valid[0] = 1'b0;
    end
    check_val("t3_err_seen", 32'(err_cyc >= 0), 32'd1);
    check_val("t3_err_delay", 32'(err_cyc - begin_cyc), 32'(BT));
    check_val("t3_idle", 32'(sched_busy), 32'd0);
    tx_mode = 0; begin_log.delete();
    req_valid[1] = 1'b1; req_data[15:8] = 8'h44;
    n = 0;
    while (begin_log.size() < 1 && n < 40) begin
      cycle(); n++;
      if (req_ready[1]) req_valid[1] = 1'b0;
    end
    check_val("t3_next", (begin_log.size() > 0) ? 32'(begin_log[0]) : 32'hFFFF, 32'h44);
    for (int i = 0; i < 20; i++) cycle();

    // busy held high externally blocks grants
    tx_mode = 2; grant_log.delete(); begin_log.delete();
    cycle();
    req_valid[0] = 1'b1; req_data[7:0] = 8'h55;
    for (int i = 0; i < 20; i++) cycle();
    check_val("t4_no_grant", 32'(grant_log.size()), 32'd0);
    tx_mode = 0; tx_busy_flag = 1'b0; tx_len = 0; tx_pend = 0;
    n = 0;
    while (begin_log.size() < 1 && n < 40) begin
      cycle(); n++;
      if (req_ready[0]) req_valid[0] = 1'b0;
    end
    check_val("t4_data", (begin_log.size() > 0) ? 32'(begin_log[0]) : 32'hFFFF, 32'h55);
    for (int i = 0; i < 20; i++) cycle();

    // reset during a frame in flight
    tx_fixed_dly = 1; tx_fixed_len = 8;
    req_data[7:0] = 8'h66; req_data[15:8] = 8'h77; req_valid = 3'b011;
    n = 0;
    while (!(m_active && m_seen_busy) && n < 60) begin cycle(); n++; end
    check_val("t5_in_frame", 32'(m_active && m_seen_busy), 32'd1);
    rst = 1'b1; tx_busy_flag = 1'b0; tx_pend = 0;
    cycle();
    rst = 1'b0; grant_log.delete();
    n = 0;
    while (grant_log.size() < 1 && n < 20) begin cycle(); n++; end
    check_val("t5_first_grant", (grant_log.size() > 0) ? 32'(grant_log[0]) : 32'hFFFF, 32'd0);
    req_valid = '0;
    for (int i = 0; i < 30; i++) cycle();

    // only requester 2 valid: wrap scan keeps granting it
    grant_log.delete(); begin_log.delete();
    n = 0;
    while (grant_log.size() < 3 && n < 200) begin
      if (!req_valid[2]) begin
        req_valid[2] = 1'b1;
        req_data[23:16] = 8'h80 + 8'(grant_log.size());
      end
      cycle(); n++;
      if (req_ready[2]) req_valid[2] = 1'b0;
    end
    check_val("t6_grants", 32'(grant_log.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < grant_log.size()) check_val("t6_grant_id", 32'(grant_log[i]), 32'd2);
    for (int i = 0; i < 30; i++) cycle();

    // randomized traffic against the model
    tx_fixed_dly = -1; tx_fixed_len = -1; rand_mode = 1;
    for (int i = 0; i < 3000; i++) cycle();
    rand_mode = 0; req_valid = '0;
    for (int i = 0; i < 40; i++) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
